// File: rtl/uart_rx_pkg.sv
// Shared state encoding and constants for the UART receive controller.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4,
      S_BREAK  = 3'd5
   } rx_state_t;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int PRESCALE_4   = 4;
   localparam int PRESCALE_8   = 8;
   localparam int PRESCALE_16  = 16;
   localparam int PRESCALE_32  = 32;
   localparam int MIN_PRESCALE = 4;

endpackage

// File: rtl/uart_rx_edge_sampler.sv
// Per-bit edge counter with three mid-bit samples and a majority vote.
// The vote is valid on edge mid+1 of every bit period.
module uart_rx_edge_sampler #(
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      start,
   input  logic                      run,
   input  logic                      RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] prescale,
   output logic [PRESCALE_WIDTH-1:0] edge_cnt,
   output logic                      vote,
   output logic                      vote_valid
);

   localparam logic [PRESCALE_WIDTH-1:0] ONE = PRESCALE_WIDTH'(1);
   localparam logic [PRESCALE_WIDTH-1:0] TWO = PRESCALE_WIDTH'(2);

   logic [PRESCALE_WIDTH-1:0] mid;
   logic [2:0]                smp;

   assign mid = prescale >> 1;

   // The start-detect cycle is edge 0, so sampling is enabled there too.
   always_ff @(posedge CLK) begin
      if (RST) begin
         edge_cnt <= '0;
         smp      <= '0;
      end else begin
         if (start)
            edge_cnt <= ONE;
         else if (run)
            edge_cnt <= (edge_cnt == prescale - ONE) ? '0 : edge_cnt + ONE;
         else
            edge_cnt <= '0;

         if (start || run) begin
            if (edge_cnt == mid - TWO) smp[0] <= RX_IN;
            if (edge_cnt == mid - ONE) smp[1] <= RX_IN;
            if (edge_cnt == mid)       smp[2] <= RX_IN;
         end
      end
   end

   assign vote       = (smp[0] & smp[1]) | (smp[0] & smp[2]) | (smp[1] & smp[2]);
   assign vote_valid = (edge_cnt == mid + ONE);

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled start/data/parity/stop framing with error pulses.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
//
// state    | meaning
// IDLE     | line idle, waiting for a low level
// START    | validating start bit, glitch rejected at mid-bit vote
// DATA     | shifting DATA_WIDTH bits, LSB first
// PARITY   | checking the parity bit
// STOP     | checking one or two stop bits, leaves at mid of the last
// BREAK    | all-zero frame seen, waiting for a full bit of idle high
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   input  logic                      PAR_EN,
   input  logic                      PAR_TYP,
   input  logic                      STOP2,
   output logic [DATA_WIDTH-1:0]     P_DATA,
   output logic                      Data_Valid,
   output logic                      par_err,
   output logic                      stp_err,
   output logic                      strt_glitch,
`ifdef UART_RX_BREAK_DETECT_EN
   output logic                      break_det,
`endif
   output logic                      busy
);

   localparam int BCW = $clog2(DATA_WIDTH);
   localparam logic [BCW-1:0]            BIT_LAST = BCW'(DATA_WIDTH - 1);
   localparam logic [PRESCALE_WIDTH-1:0] ONE      = PRESCALE_WIDTH'(1);

   rx_state_t                 state, nxt_state;
   logic [PRESCALE_WIDTH-1:0] prescale_l, presc_in, presc_use, edge_cnt;
   logic                      par_en_l, par_typ_l, stop2_l;
   logic [BCW-1:0]            bit_cnt;
   logic                      stop_idx;
   logic [DATA_WIDTH-1:0]     shadow;
   logic                      par_flag, stp_flag;
   logic                      vote, vote_valid;
   logic                      start_det, run, last_edge, last_stop, exp_par;
   logic                      glitch_set, frame_end, serr, dv_set, brk_hit;
`ifdef UART_RX_BREAK_DETECT_EN
   logic [PRESCALE_WIDTH-1:0] hi_cnt;
   logic                      par_bit;
`endif

   assign presc_in  = (Prescale < PRESCALE_WIDTH'(MIN_PRESCALE)) ?
                      PRESCALE_WIDTH'(MIN_PRESCALE) : Prescale;
   // In IDLE the frame has not been latched yet, so the live ratio sets sample points.
   assign presc_use = (state == S_IDLE) ? presc_in : prescale_l;
   assign start_det = (state == S_IDLE) && !RX_IN;
   assign run       = (state != S_IDLE) && (nxt_state != S_IDLE);
   assign last_edge = (edge_cnt == prescale_l - ONE);
   assign last_stop = !stop2_l || stop_idx;
   assign exp_par   = (^shadow) ^ (par_typ_l == PAR_ODD);

   uart_rx_edge_sampler #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_sampler (
      .CLK        (CLK),
      .RST        (RST),
      .start      (start_det),
      .run        (run),
      .RX_IN      (RX_IN),
      .prescale   (presc_use),
      .edge_cnt   (edge_cnt),
      .vote       (vote),
      .vote_valid (vote_valid)
   );

`ifdef UART_RX_BREAK_DETECT_EN
   assign brk_hit = (state == S_STOP) && vote_valid && !stop_idx && !vote &&
                    (shadow == '0) && (!par_en_l || !par_bit);
`else
   assign brk_hit = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= S_IDLE;
         prescale_l  <= '0;
         par_en_l    <= 1'b0;
         par_typ_l   <= 1'b0;
         stop2_l     <= 1'b0;
         bit_cnt     <= '0;
         stop_idx    <= 1'b0;
         shadow      <= '0;
         par_flag    <= 1'b0;
         stp_flag    <= 1'b0;
         P_DATA      <= '0;
         Data_Valid  <= 1'b0;
         par_err     <= 1'b0;
         stp_err     <= 1'b0;
         strt_glitch <= 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
         break_det   <= 1'b0;
         hi_cnt      <= '0;
         par_bit     <= 1'b0;
`endif
      end else begin
         state       <= nxt_state;
         Data_Valid  <= dv_set;
         par_err     <= frame_end && par_flag;
         stp_err     <= frame_end && serr;
         strt_glitch <= glitch_set;
         if (dv_set) P_DATA <= shadow;

         if (start_det) begin
            prescale_l <= presc_in;
            par_en_l   <= PAR_EN;
            par_typ_l  <= PAR_TYP;
            stop2_l    <= STOP2;
            par_flag   <= 1'b0;
            stp_flag   <= 1'b0;
            stop_idx   <= 1'b0;
            bit_cnt    <= '0;
         end

         if (state == S_DATA) begin
            if (vote_valid) shadow <= {vote, shadow[DATA_WIDTH-1:1]};
            if (last_edge && bit_cnt != BIT_LAST) bit_cnt <= bit_cnt + BCW'(1);
         end

         if (state == S_PARITY && vote_valid && (vote != exp_par)) par_flag <= 1'b1;

         if (state == S_STOP) begin
            if (vote_valid && !vote) stp_flag <= 1'b1;
            if (last_edge) stop_idx <= 1'b1;
         end
`ifdef UART_RX_BREAK_DETECT_EN
         break_det <= brk_hit;
         if (state == S_PARITY && vote_valid) par_bit <= vote;
         if (state == S_BREAK && RX_IN) hi_cnt <= hi_cnt + ONE;
         else                           hi_cnt <= '0;
`endif
      end
   end

   always_comb begin
      nxt_state = state;
      case (state)
         S_IDLE:   if (!RX_IN) nxt_state = S_START;
         S_START: begin
            if (vote_valid && vote) nxt_state = S_IDLE;
            else if (last_edge)     nxt_state = S_DATA;
         end
         S_DATA:   if (last_edge && bit_cnt == BIT_LAST)
                      nxt_state = par_en_l ? S_PARITY : S_STOP;
         S_PARITY: if (last_edge) nxt_state = S_STOP;
         S_STOP: begin
            if (brk_hit)                       nxt_state = S_BREAK;
            else if (vote_valid && last_stop)  nxt_state = S_IDLE;
         end
`ifdef UART_RX_BREAK_DETECT_EN
         S_BREAK:  if (RX_IN && hi_cnt == prescale_l - ONE) nxt_state = S_IDLE;
`endif
         default:  nxt_state = S_IDLE;
      endcase
   end

   always_comb begin
      busy       = (state != S_IDLE);
      glitch_set = (state == S_START) && vote_valid && vote;
      frame_end  = (state == S_STOP) && vote_valid && last_stop && !brk_hit;
      serr       = stp_flag || !vote;
      dv_set     = frame_end && !par_flag && !serr;
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed frames plus randomized frames
// compared against a frame-level timing/outcome model.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
   import uart_rx_pkg::*;

   localparam int DW = 8;
   localparam int PW = 6;
   localparam int K_DV = 0, K_PERR = 1, K_SERR = 2, K_GL = 3, K_BRK = 4, K_BF = 5;

   typedef struct {
      int kind;
      int cyc;
      int data;
   } ev_t;

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic          RX_IN = 1'b1;
   logic [PW-1:0] Prescale = PW'(8);
   logic          PAR_EN = 1'b0, PAR_TYP = 1'b0, STOP2 = 1'b0;
   logic [DW-1:0] P_DATA;
   logic          Data_Valid, par_err, stp_err, strt_glitch, busy;
`ifdef UART_RX_BREAK_DETECT_EN
   logic          break_det;
`endif

   int  total = 0, bad = 0;
   int  edge_n = 0;
   int  mon_c;
   logic busy_d = 1'b0;
   int  pdata_model = 0;
   ev_t obs_q[$], exp_q[$];
   int  legal[4] = '{PRESCALE_4, PRESCALE_8, PRESCALE_16, PRESCALE_32};

   uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
      .CLK         (CLK),
      .RST         (RST),
      .RX_IN       (RX_IN),
      .Prescale    (Prescale),
      .PAR_EN      (PAR_EN),
      .PAR_TYP     (PAR_TYP),
      .STOP2       (STOP2),
      .P_DATA      (P_DATA),
      .Data_Valid  (Data_Valid),
      .par_err     (par_err),
      .stp_err     (stp_err),
      .strt_glitch (strt_glitch),
`ifdef UART_RX_BREAK_DETECT_EN
      .break_det   (break_det),
`endif
      .busy        (busy)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) edge_n++;

   // Cycle c = the cycle whose values are sampled by the DUT at posedge c.
   always @(negedge CLK) begin
      mon_c = edge_n + 1;
      if (Data_Valid)  obs_q.push_back('{K_DV, mon_c, int'(P_DATA)});
      if (par_err)     obs_q.push_back('{K_PERR, mon_c, 0});
      if (stp_err)     obs_q.push_back('{K_SERR, mon_c, 0});
      if (strt_glitch) obs_q.push_back('{K_GL, mon_c, 0});
`ifdef UART_RX_BREAK_DETECT_EN
      if (break_det)   obs_q.push_back('{K_BRK, mon_c, 0});
`endif
      if (busy_d && !busy) obs_q.push_back('{K_BF, mon_c, 0});
      busy_d = busy;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: time limit expired");
      $fatal(1, "watchdog");
   end

   task automatic hold(input logic b, input int n);
      repeat (n) begin
         @(negedge CLK);
         RX_IN = b;
      end
   endtask

   // Drives one frame and pushes the events the receiver must produce.
   // bad_stop: 0 none, 1 first stop bit low, 2 second stop bit low.
   task automatic send_frame(input int data, input int preg, input bit pe, input bit pt,
                             input bit s2, input bit bad_par, input int bad_stop);
      int p, t0, te;
      bit pbit, perr, serr;
      p = (preg < MIN_PRESCALE) ? MIN_PRESCALE : preg;
      @(negedge CLK);
      Prescale = PW'(preg); PAR_EN = pe; PAR_TYP = pt; STOP2 = s2; RX_IN = 1'b0;
      t0 = edge_n + 1;
      @(negedge CLK);
      Prescale = PW'($urandom_range(0, 63));
      PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom); STOP2 = 1'($urandom);
      repeat (p - 2) @(negedge CLK);
      for (int i = 0; i < DW; i++) hold(data[i], p);
      if (pe) begin
         pbit = (^data[DW-1:0]) ^ pt ^ bad_par;
         hold(pbit, p);
      end
      for (int s = 0; s < (s2 ? 2 : 1); s++) begin
         if (bad_stop == s + 1) begin
            hold(1'b0, p / 2 + 2);
            hold(1'b1, p - p / 2 - 2);
         end else begin
            hold(1'b1, p);
         end
      end
      te   = t0 + (1 + DW + int'(pe) + int'(s2)) * p + p / 2 + 2;
      perr = pe && bad_par;
      serr = (bad_stop != 0);
      if (!perr && !serr) begin
         exp_q.push_back('{K_DV, te, data});
         pdata_model = data;
      end
      if (perr) exp_q.push_back('{K_PERR, te, 0});
      if (serr) exp_q.push_back('{K_SERR, te, 0});
      exp_q.push_back('{K_BF, te, 0});
   endtask

   task automatic check_events(input string tag);
      ev_t o, e;
      repeat (10) @(negedge CLK);
      total++;
      assert (obs_q.size() === exp_q.size()) else begin
         bad++;
         $error("FAIL %s event count: got=%0d want=%0d", tag, obs_q.size(), exp_q.size());
      end
      while (obs_q.size() > 0 && exp_q.size() > 0) begin
         o = obs_q.pop_front();
         e = exp_q.pop_front();
         total++;
         assert (o.kind === e.kind && o.cyc === e.cyc && o.data === e.data) else begin
            bad++;
            $error("FAIL %s event: got kind=%0d cyc=%0d data=%0h want kind=%0d cyc=%0d data=%0h",
                   tag, o.kind, o.cyc, o.data, e.kind, e.cyc, e.data);
         end
      end
      obs_q.delete();
      exp_q.delete();
      total++;
      assert (int'(P_DATA) === pdata_model) else begin
         bad++;
         $error("FAIL %s P_DATA hold: got=%0h want=%0h", tag, P_DATA, pdata_model);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      total++;
      assert ({P_DATA, Data_Valid, par_err, stp_err, strt_glitch, busy} === '0) else begin
         bad++;
         $error("FAIL %s outputs: got P_DATA=%0h dv=%b pe=%b se=%b gl=%b busy=%b want all 0",
                tag, P_DATA, Data_Valid, par_err, stp_err, strt_glitch, busy);
      end
`ifdef UART_RX_BREAK_DETECT_EN
      total++;
      assert (break_det === 1'b0) else begin
         bad++;
         $error("FAIL %s break_det: got=%b want=0", tag, break_det);
      end
`endif
   endtask

   initial begin
      int t0, p, data, gap, bs;
      bit pe, pt, s2, bp;

      repeat (3) @(negedge CLK);
      check_reset_outputs("reset");
      RST = 1'b0;
      hold(1'b1, 5);

      // Prescale=8, 8N1, 0xA5: Data_Valid expected at t0+78
      send_frame(32'hA5, 8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 0);
      check_events("a5_p8");

      // two-cycle start glitch
      @(negedge CLK);
      Prescale = PW'(8); RX_IN = 1'b0; t0 = edge_n + 1;
      hold(1'b0, 1);
      hold(1'b1, 12);
      exp_q.push_back('{K_GL, t0 + 6, 0});
      exp_q.push_back('{K_BF, t0 + 6, 0});
      check_events("glitch");

      // wrong parity bit at Prescale=16
      send_frame(32'h07, 16, 1'b1, PAR_EVEN, 1'b0, 1'b1, 0);
      check_events("parity_bad");

      // Prescale=4 two stop bits, second low, then back-to-back frames
      send_frame(32'h69, 4, 1'b0, PAR_EVEN, 1'b1, 1'b0, 2);
      send_frame(32'h3C, 4, 1'b0, PAR_EVEN, 1'b1, 1'b0, 0);
      send_frame(32'hC3, 4, 1'b0, PAR_EVEN, 1'b1, 1'b0, 0);
      check_events("stop2_b2b");

      // Prescale register below minimum acts as 4
      send_frame(32'h96, 2, 1'b1, PAR_ODD, 1'b0, 1'b0, 0);
      check_events("presc_clamp");

      // reset in the middle of DATA
      @(negedge CLK);
      Prescale = PW'(8); PAR_EN = 1'b0; STOP2 = 1'b0; RX_IN = 1'b0;
      repeat (7) @(negedge CLK);
      hold(1'b1, 8);
      hold(1'b0, 8);
      hold(1'b1, 3);
      @(negedge CLK);
      RST = 1'b1; RX_IN = 1'b1;
      @(negedge CLK);
      check_reset_outputs("mid_reset");
      exp_q.push_back('{K_BF, edge_n + 1, 0});
      pdata_model = 0;
      RST = 1'b0;
      hold(1'b1, 4);
      send_frame(32'h5A, 8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 0);
      check_events("after_reset");

`ifdef UART_RX_BREAK_DETECT_EN
      // line low for 20 bit times
      @(negedge CLK);
      Prescale = PW'(8); PAR_EN = 1'b0; STOP2 = 1'b0; RX_IN = 1'b0;
      t0 = edge_n + 1;
      repeat (159) @(negedge CLK);
      hold(1'b1, 20);
      exp_q.push_back('{K_BRK, t0 + 78, 0});
      exp_q.push_back('{K_BF, t0 + 168, 0});
      check_events("break");
`endif

      for (int k = 0; k < 24; k++) begin
         p    = legal[$urandom_range(0, 3)];
         pe   = 1'($urandom);
         pt   = 1'($urandom);
         s2   = 1'($urandom);
         data = int'($urandom_range(0, 255));
`ifdef UART_RX_BREAK_DETECT_EN
         if (data == 0) data = 1;
`endif
         bp   = ($urandom_range(0, 3) == 0);
         bs   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, s2 ? 2 : 1)) : 0;
         send_frame(data, p, pe, pt, s2, bp, bs);
         gap  = int'($urandom_range(0, 2 * p));
         hold(1'b1, gap);
      end
      check_events("random");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
